iir_biquad_mc: RTL and testbench

- Multi-channel, time-multiplexed Direct Form I biquad for the audio loopback path, one per codec stream.
- One shared multiplier serves all channels; each channel keeps its own x/y history.
- Coefficients are runtime-loadable through a shadow bank.
- Output uses round-half-up and saturation.
- Sits between the I2S receiver and transmitter. Replaces the fixed-coefficient, single-channel, unsaturated filter.

---
 rtl/iir_biquad_mc.sv | 200 ++++++++++++++++++++
 tb/tb_iir_biquad_mc.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed Direct Form I biquad: one shared multiplier, per-channel x/y history,
// shadow/active coefficient banks, round-half-up output with saturation.
module iir_biquad_mc #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int FRAC_W   = 14,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 40,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              bypass,
  input  logic              clear_hist,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              coef_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sat,
  output logic [1:0]        debug_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] UNITY  = COEF_W'(2 ** FRAC_W);
  localparam logic signed [ACC_W-1:0]  RND    = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [DATA_W-1:0] Y_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Y_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  ACC_HI = ACC_W'(Y_MAX);
  localparam logic signed [ACC_W-1:0]  ACC_LO = ACC_W'(Y_MIN);
  localparam logic [CH_W:0]            N_CH   = (CH_W+1)'(CHANNELS);

  logic [1:0]               state;
  logic [2:0]               k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_cur;
  logic [CH_W-1:0]          ch_cur;
  logic                     byp_cur;
  logic                     load_pend;

  logic signed [COEF_W-1:0] shadow [5];
  logic signed [COEF_W-1:0] active [5];
  logic signed [DATA_W-1:0] x1 [CHANNELS];
  logic signed [DATA_W-1:0] x2 [CHANNELS];
  logic signed [DATA_W-1:0] y1 [CHANNELS];
  logic signed [DATA_W-1:0] y2 [CHANNELS];

  logic                     accept;
  logic                     do_copy;
  logic                     ch_ok;
  logic [CH_W-1:0]          ch_sel;
  logic signed [COEF_W-1:0] m_coef;
  logic signed [DATA_W-1:0] m_opnd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shf;
  logic signed [DATA_W-1:0] y_res;
  logic                     sat_res;

  // Handshake: a sample is taken on an edge where in_valid && in_ready; in_ready is
  // only high in IDLE with no history clear and no coefficient copy outstanding.
  assign in_ready    = reset && (state == S_IDLE) && !clear_hist && !load_pend;
  assign accept      = in_valid && in_ready;
  assign do_copy     = (state == S_IDLE) && !accept && (coef_load || load_pend);
  assign debug_state = state;
  assign ch_ok       = {1'b0, ch_cur} < N_CH;
  assign ch_sel      = ch_ok ? ch_cur : '0;

  always_comb begin
    m_coef = active[0];
    m_opnd = x_cur;
    case (k)
      3'd1: begin m_coef = active[1]; m_opnd = x1[ch_sel]; end
      3'd2: begin m_coef = active[2]; m_opnd = x2[ch_sel]; end
      3'd3: begin m_coef = active[3]; m_opnd = y1[ch_sel]; end
      3'd4: begin m_coef = active[4]; m_opnd = y2[ch_sel]; end
      default: ;
    endcase
  end

  // Feedback terms (a1, a2) are subtracted.
  assign prod    = PROD_W'(m_coef) * PROD_W'(m_opnd);
  assign term    = ACC_W'(prod);
  assign acc_nxt = (k >= 3'd3) ? acc - term : acc + term;

  assign rnd = acc + RND;
  assign shf = rnd >>> FRAC_W;

  always_comb begin
    y_res   = shf[DATA_W-1:0];
    sat_res = 1'b0;
    if (byp_cur) begin
      y_res = x_cur;
    end else if (shf > ACC_HI) begin
      y_res   = Y_MAX;
      sat_res = 1'b1;
    end else if (shf < ACC_LO) begin
      y_res   = Y_MIN;
      sat_res = 1'b1;
    end
  end

  // Coefficient banks; the copy reads shadow before any same-edge write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        shadow[i] <= (i == 0) ? UNITY : '0;
        active[i] <= (i == 0) ? UNITY : '0;
      end
      load_pend <= 1'b0;
    end else begin
      if (coef_we && (coef_addr < 3'd5)) shadow[coef_addr] <= coef_wdata;
      if (do_copy) begin
        for (int i = 0; i < 5; i++) active[i] <= shadow[i];
        load_pend <= 1'b0;
      end else if (coef_load) begin
        load_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      k         <= '0;
      acc       <= '0;
      x_cur     <= '0;
      ch_cur    <= '0;
      byp_cur   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (clear_hist) begin
        state <= S_IDLE;
        k     <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              x_cur   <= in_data;
              ch_cur  <= in_ch;
              byp_cur <= bypass;
              acc     <= '0;
              k       <= '0;
              state   <= S_MAC;
            end
          end
          S_MAC: begin
            acc <= acc_nxt;
            if (k == 3'd4) state <= S_WB;
            else           k     <= k + 3'd1;
          end
          S_WB: begin
            state <= S_IDLE;
            // Samples tagged with a nonexistent channel are silently dropped.
            if (ch_ok) begin
              out_valid      <= 1'b1;
              out_data       <= y_res;
              out_ch         <= ch_cur;
              out_sat        <= sat_res;
              x2[ch_sel]     <= x1[ch_sel];
              x1[ch_sel]     <= x_cur;
              y2[ch_sel]     <= y1[ch_sel];
              y1[ch_sel]     <= y_res;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Bench for iir_biquad_mc: directed and random samples scored against an arithmetic
// biquad model, expected outputs queued at accept and checked by a monitor.
module tb_iir_biquad_mc;

  localparam int W = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [0:0]  in_ch = '0;
  logic        bypass = 1'b0;
  logic        clear_hist = 1'b0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        coef_load = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [0:0]  out_ch;
  logic        out_sat;
  logic [1:0]  debug_state;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  int shd[5];
  int act[5];
  int mx1[2], mx2[2], my1[2], my2[2];
  bit pend;

  iir_biquad_mc dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .bypass(bypass), .clear_hist(clear_hist),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_load(coef_load),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      shd[i] = (i == 0) ? 16384 : 0;
      act[i] = shd[i];
    end
    for (int c = 0; c < 2; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
    pend = 0;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
  endfunction

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, then round-half-up, >>14, clip to int16.
  function automatic void model_sample(input int x, input int c, input bit byp, input int acc_cyc);
    longint a;
    int y;
    bit s;
    logic [31:0] ec;
    logic [0:0]  ch1;
    logic [15:0] y16;
    s = 0;
    if (byp) begin
      y = x;
    end else begin
      a = longint'(act[0]) * x + longint'(act[1]) * mx1[c] + longint'(act[2]) * mx2[c]
        - longint'(act[3]) * my1[c] - longint'(act[4]) * my2[c];
      a = (a + 8192) >>> 14;
      if (a > 32767) begin y = 32767; s = 1; end
      else if (a < -32768) begin y = -32768; s = 1; end
      else y = int'(a);
    end
    mx2[c] = mx1[c]; mx1[c] = x;
    my2[c] = my1[c]; my1[c] = y;
    ec  = 32'(acc_cyc + 6);
    ch1 = 1'(c);
    y16 = 16'(y);
    exp_q.push_back({ec, ch1, s, y16});
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(in_ready), 1);
  endtask

  task automatic send(input int x, input int c, input bit byp, input bit push);
    int ac;
    wait_ready("in_ready_wait");
    if (!in_ready) return;
    if (pend) begin
      for (int i = 0; i < 5; i++) act[i] = shd[i];
      pend = 0;
    end
    in_valid = 1'b1;
    in_data  = 16'(x);
    in_ch    = 1'(c);
    bypass   = byp;
    @(posedge clk); #1;
    ac       = cyc;
    in_valid = 1'b0;
    bypass   = 1'b0;
    if (push) model_sample(x, c, byp, ac);
  endtask

  task automatic wr(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 3'(addr);
    coef_wdata = 16'(val);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (addr < 5) shd[addr] = val;
  endtask

  task automatic load_now();
    wait_ready("load_ready_wait");
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
    for (int i = 0; i < 5; i++) act[i] = shd[i];
  endtask

  task automatic load_defer();
    coef_load = 1'b1;
    @(posedge clk); #1;
    coef_load = 1'b0;
    pend = 1;
  endtask

  task automatic wr_load(input int addr, input int val);
    wait_ready("wr_load_ready_wait");
    coef_we    = 1'b1;
    coef_load  = 1'b1;
    coef_addr  = 3'(addr);
    coef_wdata = 16'(val);
    @(posedge clk); #1;
    coef_we   = 1'b0;
    coef_load = 1'b0;
    for (int i = 0; i < 5; i++) act[i] = shd[i];
    shd[addr] = val;
  endtask

  task automatic clear();
    clear_hist = 1'b1;
    @(posedge clk); #1;
    clear_hist = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", exp_q.size(), 0);
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: ch %0d data %0d, required no output", out_ch, $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          if (cyc != int'(e[49:18]) || out_ch != e[17] || out_sat != e[16] || out_data != e[15:0]) begin
            n_fail++;
            $display("FAIL out_sample: cycle %0d ch %0d sat %0d data %0d, required cycle %0d ch %0d sat %0d data %0d",
                     cyc, out_ch, out_sat, $signed(out_data),
                     e[49:18], e[17], e[16], $signed(e[15:0]));
          end
        end
      end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][49:18])) begin
        n_tests++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL missing_output: no out_valid by cycle %0d, required data %0d on ch %0d",
                 cyc, $signed(e[15:0]), e[17]);
      end
    end
  endtask

  initial begin
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_state", int'(debug_state), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Unity default, rounding at half gain, saturation both ways, bypass.
    send(1000, 0, 0, 1);
    drain();
    wr(0, 8192); load_now();
    send(1001, 0, 0, 1);
    send(-1001, 0, 0, 1);
    wr(0, 32767); load_now();
    send(30000, 0, 0, 1);
    send(-30000, 0, 0, 1);
    send(-12345, 1, 1, 1);
    drain();

    // First-order recursion on ch0 with ch1 idle-zero interleaved.
    wr(0, 16384); wr(3, -8192); load_now(); clear();
    send(16384, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      send(0, 1, 0, 1);
      send(0, 0, 0, 1);
    end
    send(0, 1, 0, 1);
    drain();

    // History clear during a MAC sequence aborts that sample.
    clear();
    send(16384, 0, 0, 1);
    send(0, 0, 0, 0);
    @(posedge clk); #1;
    clear();
    send(0, 0, 0, 1);
    drain();

    // Deferred load, and write+load on the same edge.
    wr(3, 0); wr(0, 16384); load_now(); clear();
    send(1000, 0, 0, 1);
    wr(0, 8192);
    load_defer();
    send(1000, 1, 0, 1);
    wr(0, 16384);
    wr_load(0, 4096);
    send(1000, 1, 0, 1);
    load_now();
    send(1000, 0, 0, 1);
    drain();

    // Random coefficients and samples.
    clear();
    for (int i = 0; i < 40; i++) begin
      logic signed [15:0] r;
      if (i % 10 == 0) begin
        for (int j = 0; j < 5; j++) begin
          r = 16'($urandom);
          if (j >= 3) r = r >>> 2;
          wr(j, int'(r));
        end
        load_now();
      end
      r = 16'($urandom);
      send(int'(r), int'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1);
    end
    drain();

    // Reset in the middle of a MAC sequence.
    send(777, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_ch", int'(out_ch), 0);
    chk("midrst_out_sat", int'(out_sat), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_state", int'(debug_state), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_rst_state", int'(debug_state), 0);
    chk("after_rst_in_ready", int'(in_ready), 1);
    send(-5, 0, 0, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
